// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed 7-segment driver: prescaled digit scan with a blanking guard
// at each slot start, and shadow pattern registers that swap only at frame boundaries.
module seg7_scan_mux #(
  parameter int DIV   = 8,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       rst_syn,
  input  logic [7:0] seg0,
  input  logic [7:0] seg1,
  input  logic [7:0] seg2,
  input  logic [7:0] seg3,
  input  logic       upd,
  input  logic [3:0] en_mask,
  output logic [7:0] seg_out,
  output logic [3:0] an_out,
  output logic       frame_done,
  output logic       upd_ack
);

  localparam int DATA_W = 8;
  localparam int CW     = $clog2(DIV);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]     CNT_BLANK = CW'(BLANK);
  localparam logic [DATA_W-1:0] SEG_OFF   = '1;
  localparam logic [3:0]        AN_OFF    = 4'hF;

  logic [CW-1:0]     cnt_p0;
  logic [1:0]        idx_p0;
  logic [DATA_W-1:0] active_p0  [4];
  logic [DATA_W-1:0] pending_p0 [4];
  logic [DATA_W-1:0] seg_in     [4];
  logic              pend_p0;
  logic              boundary;
  logic              xfer;
  logic [DATA_W-1:0] seg_nxt;
  logic [3:0]        an_nxt;
  logic [DATA_W-1:0] seg_p1;
  logic [3:0]        an_p1;
  logic              frame_p1;
  logic              ack_p1;

  // Drive only past the guard window and only when the current digit is enabled.
  function automatic logic slot_drive(input logic [CW-1:0] c, input logic [3:0] mask,
                                      input logic [1:0] i);
    return (c >= CNT_BLANK) && mask[i];
  endfunction

  assign seg_in[0] = seg0;
  assign seg_in[1] = seg1;
  assign seg_in[2] = seg2;
  assign seg_in[3] = seg3;

  assign boundary = (cnt_p0 == CNT_LAST) && (idx_p0 == 2'd3);
  assign xfer     = boundary && (upd || pend_p0);

  // ---- stage p0: scan counters and pattern registers ----
  always_ff @(posedge clk) begin
    if (rst_syn) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
    end else if (cnt_p0 == CNT_LAST) begin
      cnt_p0 <= '0;
      idx_p0 <= idx_p0 + 2'd1;
    end else begin
      cnt_p0 <= cnt_p0 + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_syn) begin
      for (int i = 0; i < 4; i++) begin
        active_p0[i]  <= SEG_OFF;
        pending_p0[i] <= SEG_OFF;
      end
      pend_p0 <= 1'b0;
    end else if (boundary) begin
      // A strobe landing on the boundary bypasses the shadow and wins over older pending data.
      if (upd) begin
        for (int i = 0; i < 4; i++) active_p0[i] <= seg_in[i];
      end else if (pend_p0) begin
        for (int i = 0; i < 4; i++) active_p0[i] <= pending_p0[i];
      end
      pend_p0 <= 1'b0;
    end else if (upd) begin
      for (int i = 0; i < 4; i++) pending_p0[i] <= seg_in[i];
      pend_p0 <= 1'b1;
    end
  end

  always_comb begin
    seg_nxt = SEG_OFF;
    an_nxt  = AN_OFF;
    if (slot_drive(cnt_p0, en_mask, idx_p0)) begin
      seg_nxt = active_p0[idx_p0];
      an_nxt  = ~(4'b0001 << idx_p0);
    end
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk) begin
    if (rst_syn) begin
      seg_p1   <= SEG_OFF;
      an_p1    <= AN_OFF;
      frame_p1 <= 1'b0;
      ack_p1   <= 1'b0;
    end else begin
      seg_p1   <= seg_nxt;
      an_p1    <= an_nxt;
      frame_p1 <= boundary;
      ack_p1   <= xfer;
    end
  end

  assign seg_out    = seg_p1;
  assign an_out     = an_p1;
  assign frame_done = frame_p1;
  assign upd_ack    = ack_p1;

endmodule
